// File: rtl/bullet_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the player bullet scheduler.
package bullet_pkg;

    localparam int COORD_W        = 10;
    localparam int NUM_SLOTS      = 3;
    localparam int SPAWN_Y_OFFSET = 10;
    localparam int AGE_W          = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPAWN    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    function automatic logic [1:0] count_active(input logic [NUM_SLOTS-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + 2'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bullet_slot_timer.sv
// One bullet slot: live flag plus frame age. The owner decides when to retire,
// using the expired flag this block raises on the final frame of the lifetime.
module bullet_slot_timer
    import bullet_pkg::*;
#(
    parameter int LIFETIME_FRAMES = 120
)(
    input  logic clk,
    input  logic rst,
    input  logic pixpulse,
    input  logic spawn,
    input  logic hit,
    input  logic frame_tick,
    output logic active,
    output logic expired
);

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(LIFETIME_FRAMES - 1);

    logic [AGE_W-1:0] age;

    assign expired = active && frame_tick && (age == AGE_LAST);

    // A fresh spawn always wins, so a stale retire request cannot kill a new bullet.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            age    <= '0;
        end else if (pixpulse) begin
            if (spawn) begin
                active <= 1'b1;
                age    <= '0;
            end else if (active) begin
                if (hit) begin
                    active <= 1'b0;
                end else if (frame_tick) begin
                    age <= age + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Player bullet pool scheduler: turns fire presses into slot spawns, enforces a
// frame cooldown, retires slots on hit or old age and issues the move strobe.
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int LIFETIME_FRAMES = 120,
    parameter int MOVE_DIV        = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pixpulse,
    input  logic                 frame_tick,
    input  logic                 fire_btn,
    input  logic [COORD_W-1:0]   ship_x,
    input  logic [COORD_W-1:0]   ship_y,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_spawn,
    output logic [COORD_W-1:0]   spawn_x,
    output logic [COORD_W-1:0]   spawn_y,
    output logic                 move,
    output logic [1:0]           bullet_count
);

    localparam logic [7:0]         COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
    localparam logic [3:0]         MOVE_LAST     = 4'(MOVE_DIV - 1);
    localparam logic [COORD_W-1:0] Y_OFFSET      = COORD_W'(SPAWN_Y_OFFSET);

    state_t               state;
    logic                 pending;
    logic                 fire_prev;
    logic                 fire_rise;
    logic [7:0]           cooldown;
    logic [3:0]           move_div;
    logic [NUM_SLOTS-1:0] free_sel;
    logic                 free_found;
    logic [NUM_SLOTS-1:0] slot_expired;
    logic [NUM_SLOTS-1:0] slot_retire;
    logic [COORD_W-1:0]   spawn_y_next;

    assign fire_rise    = fire_btn & ~fire_prev;
    assign spawn_y_next = (ship_y < Y_OFFSET) ? '0 : ship_y - Y_OFFSET;
    assign slot_retire  = hit | slot_expired;

    // Lowest-index free slot; uses registered activity so a slot retired this
    // cycle only becomes allocatable on the next one.
    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bullet_slot_timer #(
            .LIFETIME_FRAMES(LIFETIME_FRAMES)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .pixpulse  (pixpulse),
            .spawn     (slot_spawn[g]),
            .hit       (slot_retire[g]),
            .frame_tick(frame_tick),
            .active    (slot_active[g]),
            .expired   (slot_expired[g])
        );
    end

    // Presses are only latched while idle, so anything during spawn or
    // cooldown is dropped rather than queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            fire_prev    <= 1'b0;
            cooldown     <= '0;
            move_div     <= '0;
            move         <= 1'b0;
            slot_spawn   <= '0;
            spawn_x      <= '0;
            spawn_y      <= '0;
            bullet_count <= '0;
        end else if (pixpulse) begin
            fire_prev    <= fire_btn;
            slot_spawn   <= '0;
            move         <= 1'b0;
            bullet_count <= count_active(slot_active);

            if (frame_tick) begin
                if (move_div == MOVE_LAST) begin
                    move     <= 1'b1;
                    move_div <= '0;
                end else begin
                    move_div <= move_div + 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        if (free_found) begin
                            slot_spawn <= free_sel;
                            spawn_x    <= ship_x;
                            spawn_y    <= spawn_y_next;
                            state      <= SPAWN;
                        end else begin
                            pending <= 1'b0;
                        end
                    end else if (fire_rise) begin
                        pending <= 1'b1;
                    end
                end
                SPAWN: begin
                    pending  <= 1'b0;
                    cooldown <= COOLDOWN_LOAD;
                    state    <= COOLDOWN;
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cooldown <= 8'd1) begin
                            cooldown <= '0;
                            state    <= IDLE;
                        end else begin
                            cooldown <= cooldown - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: directed vectors, corner sequences
// and a randomized run against a frame/slot level reference model.
module tb_bullet_scheduler;

    localparam int FRAME_LEN  = 4;
    localparam int COOLDOWN   = 8;
    localparam int LIFETIME   = 120;
    localparam int MOVE_DIV_A = 1;
    localparam int MOVE_DIV_B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pixpulse;
    logic       frame_tick;
    logic       fire_btn;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [2:0] hit;

    logic [2:0] slot_active, slot_spawn;
    logic [9:0] spawn_x, spawn_y;
    logic       move;
    logic [1:0] bullet_count;

    logic [2:0] slot_active_b, slot_spawn_b;
    logic [9:0] spawn_x_b, spawn_y_b;
    logic       move_b;
    logic [1:0] bullet_count_b;

    logic [31:0] dut_vec, dut_b_vec;

    int compared   = 0;
    int mismatched = 0;
    int spawn_seen, move_seen_a, move_seen_b;
    logic [2:0] last_spawn;

    // reference model state
    logic [2:0] m_active;
    int         m_age [3];
    int         m_spawn_slot;
    int         m_cool_left;
    bit         m_armed, m_prev_btn;
    int         m_div_a, m_div_b;
    bit         m_move_a, m_move_b;
    int         m_count;
    logic [9:0] m_x, m_y;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
    } coord_vec_t;

    coord_vec_t vecs [5];

    bullet_scheduler #(
        .COOLDOWN_FRAMES(COOLDOWN), .LIFETIME_FRAMES(LIFETIME), .MOVE_DIV(MOVE_DIV_A)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .frame_tick(frame_tick),
        .fire_btn(fire_btn), .ship_x(ship_x), .ship_y(ship_y), .hit(hit),
        .slot_active(slot_active), .slot_spawn(slot_spawn), .spawn_x(spawn_x),
        .spawn_y(spawn_y), .move(move), .bullet_count(bullet_count)
    );

    bullet_scheduler #(
        .COOLDOWN_FRAMES(COOLDOWN), .LIFETIME_FRAMES(LIFETIME), .MOVE_DIV(MOVE_DIV_B)
    ) dut_b (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .frame_tick(frame_tick),
        .fire_btn(fire_btn), .ship_x(ship_x), .ship_y(ship_y), .hit(hit),
        .slot_active(slot_active_b), .slot_spawn(slot_spawn_b), .spawn_x(spawn_x_b),
        .spawn_y(spawn_y_b), .move(move_b), .bullet_count(bullet_count_b)
    );

    always #5 clk = ~clk;

    assign dut_vec   = {3'b0, slot_spawn, slot_active, bullet_count, move, spawn_x, spawn_y};
    assign dut_b_vec = {3'b0, slot_spawn_b, slot_active_b, bullet_count_b, move_b, spawn_x_b, spawn_y_b};

    function automatic logic [31:0] model_vec(input bit mv);
        logic [2:0] sp;
        sp = (m_spawn_slot >= 0) ? 3'(1 << m_spawn_slot) : 3'b000;
        return {3'b0, sp, m_active, 2'(m_count), mv, m_x, m_y};
    endfunction

    task automatic modelReset();
        m_active     = '0;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
        m_spawn_slot = -1;
        m_cool_left  = 0;
        m_armed      = 0;
        m_prev_btn   = 0;
        m_div_a      = 0;
        m_div_b      = 0;
        m_move_a     = 0;
        m_move_b     = 0;
        m_count      = 0;
        m_x          = '0;
        m_y          = '0;
    endtask

    // One pixpulse step of the pool rules, using the inputs present at the edge.
    task automatic modelStep();
        logic [2:0] old_act;
        int         free_idx;
        old_act = m_active;
        m_count = $countones(old_act);
        for (int i = 0; i < 3; i++) begin
            if (m_spawn_slot == i) begin
                m_active[i] = 1'b1;
                m_age[i]    = 0;
            end else if (old_act[i]) begin
                if (hit[i] || (frame_tick && m_age[i] == LIFETIME - 1)) m_active[i] = 1'b0;
                else if (frame_tick) m_age[i] = m_age[i] + 1;
            end
        end
        m_move_a = 0;
        m_move_b = 0;
        if (frame_tick) begin
            m_div_a  = (m_div_a + 1) % MOVE_DIV_A;
            m_move_a = (m_div_a == 0);
            m_div_b  = (m_div_b + 1) % MOVE_DIV_B;
            m_move_b = (m_div_b == 0);
        end
        if (m_spawn_slot >= 0) begin
            m_spawn_slot = -1;
            m_armed      = 0;
            m_cool_left  = COOLDOWN;
        end else if (m_cool_left > 0) begin
            if (frame_tick) m_cool_left = m_cool_left - 1;
        end else if (m_armed) begin
            free_idx = -1;
            for (int i = 2; i >= 0; i--) if (!old_act[i]) free_idx = i;
            if (free_idx >= 0) begin
                m_spawn_slot = free_idx;
                m_x = ship_x;
                m_y = (ship_y >= 10'd10) ? ship_y - 10'd10 : 10'd0;
            end else begin
                m_armed = 0;
            end
        end else if (fire_btn && !m_prev_btn) begin
            m_armed = 1;
        end
        m_prev_btn = fire_btn;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) modelReset();
        else if (pixpulse) modelStep();
        #1;
        if (slot_spawn != 3'b0 && last_spawn == 3'b0) spawn_seen++;
        last_spawn = slot_spawn;
        if (move) move_seen_a++;
        if (move_b) move_seen_b++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fire, input logic tick, input logic [2:0] hitv);
        fire_btn   = fire;
        frame_tick = tick;
        hit        = hitv;
        step();
        frame_tick = 1'b0;
        hit        = 3'b0;
    endtask

    task automatic runFrames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                applyStimulus(fire_btn, (c == FRAME_LEN - 1), 3'b0);
            end
        end
    endtask

    task automatic press(output logic [2:0] seen);
        applyStimulus(1'b1, 1'b0, 3'b0);
        applyStimulus(1'b0, 1'b0, 3'b0);
        seen = slot_spawn;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        pixpulse   = 1'b1;
        fire_btn   = 1'b0;
        frame_tick = 1'b0;
        hit        = 3'b0;
        step();
        step();
        rst         = 1'b0;
        last_spawn  = 3'b0;
        spawn_seen  = 0;
        move_seen_a = 0;
        move_seen_b = 0;
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] seen;

        rst = 1'b1; pixpulse = 1'b0; frame_tick = 1'b0; fire_btn = 1'b0;
        ship_x = 10'd0; ship_y = 10'd0; hit = 3'b0; last_spawn = 3'b0;
        spawn_seen = 0; move_seen_a = 0; move_seen_b = 0;
        modelReset();

        vecs[0] = '{10'd320,  10'd240,  10'd320,  10'd230};
        vecs[1] = '{10'd0,    10'd5,    10'd0,    10'd0};
        vecs[2] = '{10'd639,  10'd10,   10'd639,  10'd0};
        vecs[3] = '{10'd100,  10'd11,   10'd100,  10'd1};
        vecs[4] = '{10'd1023, 10'd1023, 10'd1023, 10'd1013};

        doReset();
        checkOutput("reset_state", dut_vec, 32'd0);

        // first spawn timing and spawn coordinates
        for (int k = 0; k < 5; k++) begin
            doReset();
            ship_x = vecs[k].x;
            ship_y = vecs[k].y;
            applyStimulus(1'b1, 1'b0, 3'b0);
            checkOutput("spawn_early", slot_spawn, 3'b000);
            applyStimulus(1'b0, 1'b0, 3'b0);
            checkOutput("spawn_slot", slot_spawn, 3'b001);
            checkOutput("spawn_x", spawn_x, vecs[k].exp_x);
            checkOutput("spawn_y", spawn_y, vecs[k].exp_y);
            applyStimulus(1'b0, 1'b0, 3'b0);
            checkOutput("spawn_one_wide", slot_spawn, 3'b000);
            checkOutput("active_after_spawn", slot_active, 3'b001);
            applyStimulus(1'b0, 1'b0, 3'b0);
            checkOutput("count_one", bullet_count, 2'd1);
        end

        // button held for 100 frames gives a single shot
        doReset();
        ship_x = 10'd320; ship_y = 10'd240;
        fire_btn = 1'b1;
        runFrames(100);
        fire_btn = 1'b0;
        checkOutput("held_single_spawn", spawn_seen, 1);
        checkOutput("held_count", bullet_count, 2'd1);

        // second press after the cooldown lands in slot 1
        doReset();
        press(seen);
        checkOutput("cool_first", seen, 3'b001);
        runFrames(COOLDOWN);
        press(seen);
        checkOutput("cool_second_slot1", seen, 3'b010);

        // press during cooldown is dropped
        doReset();
        press(seen);
        runFrames(4);
        spawn_seen = 0;
        press(seen);
        checkOutput("cool_press_ignored", seen, 3'b000);
        runFrames(6);
        checkOutput("cool_no_late_spawn", spawn_seen, 0);

        // full pool, dropped press, then hit frees slot 1
        doReset();
        press(seen); runFrames(COOLDOWN);
        press(seen); runFrames(COOLDOWN);
        press(seen);
        checkOutput("fill_third", seen, 3'b100);
        runFrames(COOLDOWN);
        checkOutput("full_active", slot_active, 3'b111);
        checkOutput("full_count", bullet_count, 2'd3);
        press(seen);
        checkOutput("full_press_dropped", seen, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("full_count_stays", bullet_count, 2'd3);
        applyStimulus(1'b0, 1'b0, 3'b010);
        checkOutput("hit_retires", slot_active, 3'b101);
        applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("hit_count", bullet_count, 2'd2);
        press(seen);
        checkOutput("refill_slot1", seen, 3'b010);

        // lifetime expiry on the 120th frame tick
        doReset();
        press(seen);
        runFrames(LIFETIME - 1);
        checkOutput("life_still_active", slot_active, 3'b001);
        runFrames(1);
        checkOutput("life_retired", slot_active, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("life_count_zero", bullet_count, 2'd0);

        // reset in the spawn cycle, with pixpulse low
        doReset();
        press(seen);
        checkOutput("rst_pre_spawn", seen, 3'b001);
        rst = 1'b1; pixpulse = 1'b0;
        step();
        checkOutput("rst_in_spawn", dut_vec, 32'd0);
        checkOutput("rst_in_spawn_b", dut_b_vec, 32'd0);
        rst = 1'b0; pixpulse = 1'b1; spawn_seen = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("rst_abandons_spawn", {29'd0, slot_active}, 32'd0);
        checkOutput("rst_no_spawn", spawn_seen, 0);

        // move divider
        doReset();
        runFrames(1);
        checkOutput("move_a_first", move, 1'b1);
        checkOutput("move_b_first", move_b, 1'b0);
        runFrames(1);
        checkOutput("move_b_second", move_b, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("move_b_one_wide", move_b, 1'b0);
        runFrames(4);
        applyStimulus(1'b0, 1'b0, 3'b0);
        checkOutput("move_a_count", move_seen_a, 6);
        checkOutput("move_b_count", move_seen_b, 3);

        // randomized run against the reference model
        doReset();
        for (int i = 0; i < 4000; i++) begin
            pixpulse   = ($urandom_range(0, 3) != 0);
            frame_tick = pixpulse && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) fire_btn = ~fire_btn;
            hit = 3'b0;
            if ((i % 2000) < 1000) begin
                for (int b = 0; b < 3; b++) hit[b] = ($urandom_range(0, 39) == 0);
            end
            ship_x = 10'($urandom_range(0, 1023));
            ship_y = 10'($urandom_range(0, 40));
            step();
            checkOutput("rand_dut", dut_vec, model_vec(m_move_a));
            checkOutput("rand_dut_b", dut_b_vec, model_vec(m_move_b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
